// File: rtl/alu_pipe_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_regfile_if
// Purpose  : Command/response bundle for the pipelined ALU + register file.
// Revision : 1.0
// ============================================================================
interface alu_pipe_regfile_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [ADDR_BITS-1:0] addr_a;
    logic [ADDR_BITS-1:0] addr_b;
    logic [ADDR_BITS-1:0] addr_r;
    logic [DATA_BITS-1:0] data_in;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_BITS-1:0] data_out;
    logic [3:0]           flags;

    modport master (
        output cmd_valid, cmd_op, addr_a, addr_b, addr_r, data_in, rsp_ready,
        input  cmd_ready, rsp_valid, data_out, flags
    );

    modport slave (
        input  cmd_valid, cmd_op, addr_a, addr_b, addr_r, data_in, rsp_ready,
        output cmd_ready, rsp_valid, data_out, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_regfile
// Purpose  : Two-stage ALU/register file with forwarding, flags and a
//            backpressured response register.
// Revision : 1.0
// ============================================================================
module alu_pipe_regfile #(
    parameter int DATA_BITS = 8,
    parameter int REG_COUNT = 16,
    parameter int ADDR_BITS = 4
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    alu_pipe_regfile_if.slave    bus
);
    localparam logic [2:0] c_op_nop   = 3'd0;
    localparam logic [2:0] c_op_read  = 3'd1;
    localparam logic [2:0] c_op_write = 3'd2;
    localparam logic [2:0] c_op_add   = 3'd3;
    localparam logic [2:0] c_op_sub   = 3'd4;
    localparam logic [2:0] c_op_adc   = 3'd5;
    localparam logic [2:0] c_op_and   = 3'd6;
    localparam logic [2:0] c_op_xor   = 3'd7;
    localparam logic [ADDR_BITS:0] c_reg_count = (ADDR_BITS+1)'(REG_COUNT);
    localparam int c_msb = DATA_BITS - 1;

    logic [DATA_BITS-1:0] r_regs [REG_COUNT];
    logic                 r_ex_valid;
    logic [2:0]           r_ex_op;
    logic [DATA_BITS-1:0] r_ex_a;
    logic [DATA_BITS-1:0] r_ex_b;
    logic [DATA_BITS-1:0] r_ex_din;
    logic [ADDR_BITS-1:0] r_ex_waddr;
    logic                 r_rsp_valid;
    logic [DATA_BITS-1:0] r_data_out;
    logic [3:0]           r_flags;

    logic                 w_advance, w_retire, w_cmd_ready, w_issue, w_ex_wr_en;
    logic                 w_a_in_range, w_b_in_range;
    logic [DATA_BITS-1:0] w_file_a, w_file_b, w_opnd_a, w_opnd_b;
    logic [DATA_BITS-1:0] w_b_eff, w_ex_result;
    logic [DATA_BITS:0]   w_sum;
    logic                 w_cin, w_c, w_v, w_is_alu;
    logic [3:0]           w_ex_flags;

    assign w_advance   = !r_rsp_valid || bus.rsp_ready;
    assign w_retire    = r_ex_valid && w_advance;
    assign w_cmd_ready = !r_ex_valid || w_advance;
    assign w_issue     = bus.cmd_valid && w_cmd_ready && (bus.cmd_op != c_op_nop);

    // Out-of-range addresses read as zero and never get written.
    assign w_a_in_range = {1'b0, bus.addr_a} < c_reg_count;
    assign w_b_in_range = {1'b0, bus.addr_b} < c_reg_count;
    assign w_file_a     = w_a_in_range ? r_regs[bus.addr_a] : '0;
    assign w_file_b     = w_b_in_range ? r_regs[bus.addr_b] : '0;
    assign w_ex_wr_en   = w_retire && (r_ex_op != c_op_read)
                          && ({1'b0, r_ex_waddr} < c_reg_count);

    // A retiring write bypasses the file so a back-to-back reader sees it.
    assign w_opnd_a = (w_ex_wr_en && r_ex_waddr == bus.addr_a) ? w_ex_result : w_file_a;
    assign w_opnd_b = (w_ex_wr_en && r_ex_waddr == bus.addr_b) ? w_ex_result : w_file_b;

    always_comb begin
        w_b_eff     = (r_ex_op == c_op_sub) ? ~r_ex_b : r_ex_b;
        w_cin       = (r_ex_op == c_op_sub) ? 1'b1
                    : (r_ex_op == c_op_adc) ? r_flags[1] : 1'b0;
        w_sum       = {1'b0, r_ex_a} + {1'b0, w_b_eff} + {{DATA_BITS{1'b0}}, w_cin};
        w_ex_result = '0;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_is_alu    = 1'b0;
        case (r_ex_op)
            c_op_read:  w_ex_result = r_ex_a;
            c_op_write: w_ex_result = r_ex_din;
            c_op_add, c_op_sub, c_op_adc: begin
                w_ex_result = w_sum[DATA_BITS-1:0];
                w_c         = w_sum[DATA_BITS];
                w_v         = (r_ex_a[c_msb] == w_b_eff[c_msb]) && (w_sum[c_msb] != r_ex_a[c_msb]);
                w_is_alu    = 1'b1;
            end
            c_op_and: begin
                w_ex_result = r_ex_a & r_ex_b;
                w_is_alu    = 1'b1;
            end
            c_op_xor: begin
                w_ex_result = r_ex_a ^ r_ex_b;
                w_is_alu    = 1'b1;
            end
            default: w_ex_result = '0;
        endcase
        w_ex_flags = w_is_alu ? {w_ex_result[c_msb], w_v, w_c, (w_ex_result == '0)} : r_flags;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_op     <= c_op_nop;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_din    <= '0;
            r_ex_waddr  <= '0;
            r_rsp_valid <= 1'b0;
            r_data_out  <= '0;
            r_flags     <= '0;
        end else begin
            if (w_issue) begin
                r_ex_op    <= bus.cmd_op;
                r_ex_a     <= w_opnd_a;
                r_ex_b     <= w_opnd_b;
                r_ex_din   <= bus.data_in;
                r_ex_waddr <= (bus.cmd_op == c_op_write) ? bus.addr_a : bus.addr_r;
            end
            if (w_issue) begin
                r_ex_valid <= 1'b1;
            end else if (w_retire) begin
                r_ex_valid <= 1'b0;
            end
            if (w_retire) begin
                r_rsp_valid <= 1'b1;
                r_data_out  <= w_ex_result;
                r_flags     <= w_ex_flags;
            end else if (bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ex_wr_en) begin
            r_regs[r_ex_waddr] <= w_ex_result;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.data_out  = r_data_out;
    assign bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe_regfile
// Purpose  : Random + directed bench for alu_pipe_regfile (16-bit, 12 regs)
//            against a sequential architectural model.
// Revision : 1.0
// ============================================================================
module tb_alu_pipe_regfile;
    localparam int     DW    = 16;
    localparam int     RC    = 12;
    localparam int     AW    = 4;
    localparam longint FULL  = longint'(1) << DW;
    localparam longint HALF  = longint'(1) << (DW - 1);
    localparam longint MASK  = FULL - 1;
    localparam int     TMO   = 200;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_regfile_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

    alu_pipe_regfile #(.DATA_BITS(DW), .REG_COUNT(RC), .ADDR_BITS(AW)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [3:0]    f;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_out = 0;
    bit         just_acc = 1'b0;
    bit         rand_ready = 1'b0;
    longint     mregs [RC];
    logic [3:0] mflags;
    exp_t       q [$];
    logic [DW-1:0] got_d [$];
    logic [3:0]    got_f [$];
    int            got_c [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint sgn(input longint v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Architectural model: each command executes completely, in order.
    function automatic void model_exec(input logic [2:0] op, input int a, input int b,
                                       input int r, input longint din,
                                       output longint res, output logic [3:0] fl);
        longint ra, rb, s, st;
        logic   c, v;
        int     dest;
        ra  = (a < RC) ? mregs[a] : 0;
        rb  = (b < RC) ? mregs[b] : 0;
        c   = mflags[1];
        v   = mflags[2];
        res = 0;
        case (op)
            3'd1: res = ra;
            3'd2: res = din;
            3'd3: begin s = ra + rb; st = sgn(ra) + sgn(rb); c = (s >= FULL); end
            3'd4: begin s = ra - rb; st = sgn(ra) - sgn(rb); c = (ra >= rb); end
            3'd5: begin
                s  = ra + rb + longint'(mflags[1]);
                st = sgn(ra) + sgn(rb) + longint'(mflags[1]);
                c  = (s >= FULL);
            end
            3'd6: begin s = ra & rb; st = 0; c = 1'b0; end
            default: begin s = ra ^ rb; st = 0; c = 1'b0; end
        endcase
        if (op >= 3'd3) begin
            res = s & MASK;
            v   = (st > HALF - 1) || (st < -HALF);
            mflags = {res >= HALF, v, c, res == 0};
        end
        dest = (op == 3'd2) ? a : r;
        if (op != 3'd1 && dest < RC) mregs[dest] = res;
        fl = mflags;
    endfunction

    always @(posedge clk) cyc++;

    // Compare process: handshake expectations, response contents, model update.
    always @(negedge clk) begin : mon
        logic       exp_rv;
        longint     res;
        logic [3:0] fl;
        exp_t       e;
        if (!reset_n) begin
            for (int i = 0; i < RC; i++) mregs[i] = 0;
            mflags   = 4'h0;
            q.delete();
            n_out    = 0;
            just_acc = 1'b0;
        end else begin
            exp_rv = (n_out >= 2) || (n_out == 1 && !just_acc);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'((n_out < 2) || bus.rsp_ready));
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    chk("data_out", 32'(bus.data_out), 32'(q[0].d));
                    chk("flags", 32'(bus.flags), 32'(q[0].f));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
                void'(q.pop_front());
                got_d.push_back(bus.data_out);
                got_f.push_back(bus.flags);
                got_c.push_back(cyc);
                n_out--;
            end
            just_acc = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready && bus.cmd_op != 3'd0) begin
                model_exec(bus.cmd_op, int'(bus.addr_a), int'(bus.addr_b), int'(bus.addr_r),
                           longint'(bus.data_in), res, fl);
                e.d = res[DW-1:0];
                e.f = fl;
                q.push_back(e);
                n_out++;
                just_acc = 1'b1;
            end
        end
    end

    task automatic send(input logic [2:0] op, input int a, input int b, input int r,
                        input logic [DW-1:0] din);
        bit acc;
        acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.addr_a    = AW'(a);
        bus.addr_b    = AW'(b);
        bus.addr_r    = AW'(r);
        bus.data_in   = din;
        for (int k = 0; k < TMO && !acc; k++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < TMO && n_out != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_outstanding", 32'(n_out), 32'd0);
    endtask

    initial begin : stim
        int b;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.addr_a    = '0;
        bus.addr_b    = '0;
        bus.addr_r    = '0;
        bus.data_in   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_flags", 32'(bus.flags), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        chk("reset_data_out", 32'(bus.data_out), 32'h0);

        b = got_d.size();
        for (int i = 0; i < 16; i++) send(3'd1, i, 0, 0, '0);
        drain();
        for (int i = 0; i < 16; i++) chk("reset_regread", 32'(got_d[b+i]), 32'h0);

        b = got_d.size();
        send(3'd2, 3, 0, 0, 16'h007F);
        send(3'd1, 3, 0, 0, '0);
        drain();
        chk("wr_r3", 32'(got_d[b]), 32'h7F);
        chk("rd_r3_fwd", 32'(got_d[b+1]), 32'h7F);
        chk("rd_r3_next_cycle", 32'(got_c[b+1] - got_c[b]), 32'd1);

        b = got_d.size();
        send(3'd2, 1, 0, 0, 16'hFFFF);
        send(3'd2, 2, 0, 0, 16'h0001);
        send(3'd3, 1, 2, 4, '0);
        send(3'd5, 2, 2, 5, '0);
        drain();
        chk("add_data", 32'(got_d[b+2]), 32'h0);
        chk("add_flags", 32'(got_f[b+2]), 32'b0011);
        chk("adc_data", 32'(got_d[b+3]), 32'h3);
        chk("adc_flags", 32'(got_f[b+3]), 32'b0000);

        b = got_d.size();
        send(3'd2, 6, 0, 0, 16'h8000);
        send(3'd2, 7, 0, 0, 16'h0001);
        send(3'd4, 6, 7, 8, '0);
        send(3'd4, 7, 6, 9, '0);
        send(3'd6, 1, 6, 10, '0);
        send(3'd7, 1, 1, 11, '0);
        drain();
        chk("sub_data", 32'(got_d[b+2]), 32'h7FFF);
        chk("sub_flags", 32'(got_f[b+2]), 32'b0110);
        chk("subrev_data", 32'(got_d[b+3]), 32'h8001);
        chk("subrev_flags", 32'(got_f[b+3]), 32'b1100);
        chk("and_data", 32'(got_d[b+4]), 32'h8000);
        chk("and_flags", 32'(got_f[b+4]), 32'b1000);
        chk("xor_flags", 32'(got_f[b+5]), 32'b0001);

        b = got_d.size();
        send(3'd2, 13, 0, 0, 16'h1234);
        send(3'd1, 13, 0, 0, '0);
        send(3'd3, 13, 2, 13, '0);
        drain();
        chk("oor_write_rsp", 32'(got_d[b]), 32'h1234);
        chk("oor_read", 32'(got_d[b+1]), 32'h0);
        chk("oor_add", 32'(got_d[b+2]), 32'h1);

        // Backpressure: two commands fit, the third waits for rsp_ready.
        b = got_d.size();
        bus.rsp_ready = 1'b0;
        send(3'd2, 0, 0, 0, 16'h0011);
        send(3'd2, 1, 0, 0, 16'h0022);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.addr_a    = AW'(2);
        bus.data_in   = 16'h0033;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        drain();
        chk("bp_rsp0", 32'(got_d[b]), 32'h11);
        chk("bp_rsp1", 32'(got_d[b+1]), 32'h22);
        chk("bp_rsp2", 32'(got_d[b+2]), 32'h33);

        // Asynchronous reset in the middle of a stall.
        bus.rsp_ready = 1'b0;
        send(3'd2, 3, 0, 0, 16'h0055);
        send(3'd2, 4, 0, 0, 16'h0066);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midreset_data_out", 32'(bus.data_out), 32'd0);
        chk("midreset_flags", 32'(bus.flags), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.rsp_ready = 1'b1;
        b = got_d.size();
        send(3'd1, 3, 0, 0, '0);
        send(3'd1, 6, 0, 0, '0);
        drain();
        chk("postreset_r3", 32'(got_d[b]), 32'h0);
        chk("postreset_r6", 32'(got_d[b+1]), 32'h0);

        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int ra, rb, rr;
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
            rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
            rr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
            send(3'($urandom_range(0, 7)), ra, rb, rr, DW'($urandom));
        end
        rand_ready = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_pipe_regfile.md
# alu_pipe_regfile

Parametrised two-stage successor to the 8-bit, 16-register ALU/register-file pair. It holds a configurable register file and an ALU with a wider op set and a persistent flags register. Commands arrive over a valid/ready handshake, and results leave over a valid/ready response port with backpressure. It sits between the instruction decoder (command side) and the datapath/bus interface (response side).

## Interface
- `DATA_BITS`, 8, register and ALU width (≥4)
- `REG_COUNT`, 16, number of registers (2..256)
- `ADDR_BITS`, 4, address width; must satisfy 2**ADDR_BITS ≥ REG_COUNT
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted on an edge where valid&&ready
- `cmd_op`  in  3  0 NOP, 1 REG_READ, 2 REG_WRITE, 3 ADD, 4 SUB, 5 ADC, 6 AND, 7 XOR
- `addr_a`, `addr_b`, `addr_r`  in  ADDR_BITS each  source A, source B, destination
- `data_in`  in  DATA_BITS  write data for REG_WRITE
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `data_out`  out  DATA_BITS  response data
- `flags`  out  4  {N, V, C, Z}; registered, persistent

## Operation
- **Issue stage (accept edge).**
  - Reads rA and rB and latches them with the op, addr_r/addr_a and data_in into EX; ex_valid←1.
  - NOP is accepted but never enters EX and produces no response.
- **EX stage (next advancing edge).** Computes, writes back, updates flags, and loads the response register.
  - REG_READ: data_out←rA. No write, flags unchanged.
  - REG_WRITE: reg[addr_a]←data_in; data_out←data_in. Flags unchanged.
  - ADD: r=a+b. C=carry out.
  - SUB: r=a+~b+1. C=carry out, so 1 means no borrow.
  - ADC: r=a+b+C. Uses the flags register value at EX time.
  - AND / XOR: bitwise. C←0, V←0.
  - All ALU ops: reg[addr_r]←r; data_out←r; Z=(r==0); N=r[MSB].
  - V (ADD/ADC/SUB) = signed overflow of the DATA_BITS-wide operation.
- **Width.** Results are truncated to DATA_BITS; the carry is the (DATA_BITS+1)th bit.
- **Address range.** Addresses ≥ REG_COUNT read as 0; writes to them are discarded. Flags and response are still produced.
- **Advance.** advance = !rsp_valid || rsp_ready.
  - EX retires only when ex_valid && advance.
  - cmd_ready = !ex_valid || advance (combinational, no dependence on cmd_valid).
- **Response.** rsp_valid←1 on an EX retire edge. rsp_valid←0 on an edge with rsp_ready && no retire. data_out holds while rsp_valid && !rsp_ready.
- **Forwarding.** If EX retires on the same edge that a new command is accepted, and EX writes register X that the new command reads as A or B, the latched operand is the EX result, not the stale file value. Both A and B are forwarded independently.
- **Ordering.** In-order; never reorders, drops or duplicates commands.
- **Reset.** Asserting reset_n low at any time, including mid-stall, clears immediately:
  - all registers, flags and data_out →0
  - rsp_valid, ex_valid →0
  - the in-flight command is lost
- **Out of reset.** cmd_ready=1.

## Timing
- **Latency.** Accept at edge E0 → rsp_valid high after E1, given no backpressure. Written register is visible to a command accepted at E1 via forwarding, or at E2 and later from the file.
- **Throughput.** One command per cycle with rsp_ready held high.
- **Backpressure.** With rsp_valid=1 and rsp_ready=0:
  - EX holds.
  - With EX occupied, cmd_ready=0.
  - Exactly two commands can be buffered (response register + EX) before stalling input.
- **Stall release.** Raising rsp_ready retires EX on the same edge; cmd_ready rises combinationally in that cycle.
- **Flag timing.** Flags update on the EX retire edge only; ADC directly after ADD sees the ADD's carry.

## Test plan
- **Reset.** Reset → all flags 0, rsp_valid 0, cmd_ready 1. REG_READ of every register returns 0.
- **Write/readback.** REG_WRITE r3=0x7F, then REG_READ r3 back-to-back → responses 0x7F, 0x7F on consecutive cycles (forwarding path).
- **ADD with overflow, then ADC.** r1=0xFF, r2=0x01: ADD r4=r1+r2 → data_out 0x00, Z=1, C=1, V=0. ADC r5=r2+r2 immediately after → 0x03.
- **SUB flags.** r6=0x80, r7=0x01: SUB → 0x7F, V=1, C=1, N=0. SUB r7−r6 → 0x81, C=0, N=1.
- **Backpressure.** rsp_ready=0 with three commands offered → only two accepted, cmd_ready=0. Release → responses in order, no loss. Mid-stall reset_n pulse → rsp_valid falls without a clock edge.
- **Parametrisation.** DATA_BITS=16, REG_COUNT=12: write to address 13 ignored, read of 13 returns 0. Random op stream matches a reference model over 10k commands.
